// File: rtl/contador_cascada16_pkg.sv
// contador_pkg: shared constants and helpers for the cascaded 16-bit counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   modo_t       - operating mode encoding for the MODO input
//   NIBBLE_W     - width of one counter stage
//   N_STAGES     - number of cascaded stages
//   DELTA_W      - width of the signed per-stage delta / carry-in
//   stage0_delta - signed increment applied to the least significant stage
package contador_pkg;

  typedef enum logic [1:0] {
    MODO_UP1   = 2'b00,
    MODO_DN1   = 2'b01,
    MODO_DNALT = 2'b10,
    MODO_LOAD  = 2'b11
  } modo_t;

  localparam int NIBBLE_W = 4;
  localparam int N_STAGES = 4;

  // Holds -15..+16, the full range of nibble + delta.
  localparam int DELTA_W  = 6;

  // Signed step fed into stage 0. Load mode contributes no arithmetic, so it
  // returns zero; the stage's load input takes over in that case.
  function automatic logic signed [DELTA_W-1:0] stage0_delta(
    input logic [1:0] modo,
    input int unsigned step_alt
  );
    logic signed [DELTA_W-1:0] w_d;
    w_d = '0;
    case (modo)
      MODO_UP1:   w_d = 6'sd1;
      MODO_DN1:   w_d = -6'sd1;
      MODO_DNALT: w_d = $signed(6'd0 - 6'(step_alt));
      default:    w_d = '0;
    endcase
    return w_d;
  endfunction

endpackage

// File: rtl/contador_cascada16_contador4.sv
// contador4: one combinational 4-bit stage of the cascaded counter.
// Latency: 0 cycles (pure combinational; the top level owns the registers).
// Backpressure: none; the enclosing counter decides whether a result is taken.
//
// Ports:
//   i_d        [3:0]  current nibble value
//   i_delta    [5:0]  signed delta (stage 0) or carry/borrow-in (+1/0/-1)
//   i_load            select parallel load instead of arithmetic
//   i_load_val [3:0]  parallel load nibble
//   o_q        [3:0]  next nibble value
//   o_carry           stage overflowed past 15 (counting up)
//   o_borrow          stage underflowed below 0 (counting down)
module contador4
  import contador_pkg::*;
(
  input  logic [NIBBLE_W-1:0]       i_d,
  input  logic signed [DELTA_W-1:0] i_delta,
  input  logic                      i_load,
  input  logic [NIBBLE_W-1:0]       i_load_val,
  output logic [NIBBLE_W-1:0]       o_q,
  output logic                      o_carry,
  output logic                      o_borrow
);

  logic signed [DELTA_W-1:0] w_sum;

  // Widen the nibble with zero sign bits so the sum is an ordinary signed
  // value in -15..+16.
  assign w_sum = $signed({2'b00, i_d}) + i_delta;

  always_comb begin
    o_q      = w_sum[NIBBLE_W-1:0];
    o_carry  = 1'b0;
    o_borrow = 1'b0;
    if (i_load) begin
      o_q = i_load_val;
    end else begin
      // Sign bit set means we went below zero. Bit 4 with the sign clear
      // means we reached 16 or more.
      o_borrow = w_sum[DELTA_W-1];
      o_carry  = ~w_sum[DELTA_W-1] & w_sum[NIBBLE_W];
    end
  end

endmodule

// File: rtl/contador_cascada16.sv
// contador_cascada16: 16-bit up/down/load counter built from four cascaded nibble stages.
// Latency: 1 cycle; the value and the per-stage wrap flags appear after the edge that computes them.
// Backpressure: none; ENB low holds the value and forces the flags low.
//
// Ports:
//   CLK            rising-edge clock
//   RESET_L        asynchronous active-low reset
//   ENB            count enable
//   MODO    [1:0]  00 up 1, 01 down 1, 10 down STEP_ALT, 11 parallel load
//   entrada [15:0] parallel load value
//   salida  [15:0] registered counter value
//   RCO            carry/borrow out of bits 3:0 (one-cycle pulse)
//   RCO162         carry/borrow out of bits 7:4
//   RCO163         carry/borrow out of bits 11:8
//   RCO164         carry/borrow out of bits 15:12 (full 16-bit wrap)
//   ZERO           only with CONTADOR16_ZERO_EN defined: registered salida==0
//
// Parameter STEP_ALT (1..15) sets the decrement used in MODO=10.
module contador_cascada16
  import contador_pkg::*;
#(
  parameter int unsigned STEP_ALT = 3
) (
  input  logic        CLK,
  input  logic        RESET_L,
  input  logic        ENB,
  input  logic [1:0]  MODO,
  input  logic [15:0] entrada,
  output logic [15:0] salida,
  output logic        RCO,
  output logic        RCO162,
  output logic        RCO163,
`ifdef CONTADOR16_ZERO_EN
  output logic        ZERO,
`endif
  output logic        RCO164
);

  localparam int W = NIBBLE_W * N_STAGES;

  logic [W-1:0]              r_salida;
  logic [N_STAGES-1:0]       r_rco;
  logic [W-1:0]              w_next;
  logic                      w_load;
  logic [N_STAGES-1:0]       w_carry;
  logic [N_STAGES-1:0]       w_borrow;
  logic signed [DELTA_W-1:0] w_delta [0:N_STAGES-1];

  assign w_load     = (MODO == MODO_LOAD);
  assign w_delta[0] = stage0_delta(MODO, STEP_ALT);

  // Ripple chain: stage k only ever sees a unit carry or borrow from
  // stage k-1. A -STEP_ALT step can borrow at most one from the next
  // nibble because STEP_ALT never exceeds 15.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    contador4 u_stage (
      .i_d        (r_salida[k*NIBBLE_W +: NIBBLE_W]),
      .i_delta    (w_delta[k]),
      .i_load     (w_load),
      .i_load_val (entrada[k*NIBBLE_W +: NIBBLE_W]),
      .o_q        (w_next[k*NIBBLE_W +: NIBBLE_W]),
      .o_carry    (w_carry[k]),
      .o_borrow   (w_borrow[k])
    );

    if (k < N_STAGES - 1) begin : g_link
      assign w_delta[k+1] = w_carry[k]  ?  6'sd1 :
                            w_borrow[k] ? -6'sd1 : 6'sd0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_salida <= '0;
      r_rco    <= '0;
    end else if (ENB) begin
      r_salida <= w_next;
      // The stages already report no wrap when loading.
      r_rco    <= w_carry | w_borrow;
    end else begin
      // The flags are pulses, so a held cycle clears them.
      r_rco    <= '0;
    end
  end

  assign salida = r_salida;
  assign RCO    = r_rco[0];
  assign RCO162 = r_rco[1];
  assign RCO163 = r_rco[2];
  assign RCO164 = r_rco[3];

`ifdef CONTADOR16_ZERO_EN
  logic r_zero;

  // Registered alongside salida, so ZERO is computed from the value being
  // written. Reset leaves the counter at zero, so ZERO resets high.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_zero <= 1'b1;
    end else if (ENB) begin
      r_zero <= (w_next == '0);
    end else begin
      r_zero <= (r_salida == '0);
    end
  end

  assign ZERO = r_zero;
`endif

endmodule

// File: tb/tb_contador_cascada16.sv
// tb_contador_cascada16: self-checking bench for contador_cascada16.
// Latency: n/a.
// Backpressure: n/a.
module tb_contador_cascada16;

  localparam int STEP = 3;

  logic        CLK;
  logic        RESET_L;
  logic        ENB;
  logic [1:0]  MODO;
  logic [15:0] entrada;
  logic [15:0] salida;
  logic        RCO, RCO162, RCO163, RCO164;
`ifdef CONTADOR16_ZERO_EN
  logic        ZERO;
`endif

  contador_cascada16 #(.STEP_ALT(STEP)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .ENB     (ENB),
    .MODO    (MODO),
    .entrada (entrada),
    .salida  (salida),
    .RCO     (RCO),
    .RCO162  (RCO162),
    .RCO163  (RCO163),
`ifdef CONTADOR16_ZERO_EN
    .ZERO    (ZERO),
`endif
    .RCO164  (RCO164)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: the counter value as a plain integer.
  int m_val = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compute the expected result from the arithmetic rules: the counter moves
  // by a signed amount mod 2^16, and nibble k wraps exactly when the low
  // (k+1) nibbles cannot absorb the step without crossing 0 or 16^(k+1).
  task automatic step(input logic e, input logic [1:0] m, input logic [15:0] d,
                      input string tag);
    int       nv;
    int       amt;
    int       md;
    int       low;
    logic [3:0] ef;
    ef  = '0;
    nv  = m_val;
    amt = 0;
    if (e) begin
      case (m)
        2'b00: begin nv = m_val + 1;    amt = 1;    end
        2'b01: begin nv = m_val - 1;    amt = 1;    end
        2'b10: begin nv = m_val - STEP; amt = STEP; end
        default: nv = int'(d);
      endcase
      if (m != 2'b11) begin
        for (int k = 0; k < 4; k++) begin
          md  = 1 << (4 * (k + 1));
          low = m_val % md;
          if (m == 2'b00) ef[k] = (low + amt >= md);
          else            ef[k] = (low < amt);
        end
      end
    end
    nv = ((nv % 65536) + 65536) % 65536;

    ENB = e; MODO = m; entrada = d;
    @(posedge CLK);
    @(negedge CLK);
    m_val = nv;
    chk({tag, "_val"}, 32'(salida), 32'(nv));
    chk({tag, "_rco"}, 32'({RCO164, RCO163, RCO162, RCO}), 32'(ef));
`ifdef CONTADOR16_ZERO_EN
    chk({tag, "_zero"}, 32'(ZERO), 32'(nv == 0));
`endif
  endtask

  initial begin
    logic [15:0] rv;
    logic        re;
    logic [1:0]  rm;

    RESET_L = 1'b0; ENB = 1'b0; MODO = 2'b00; entrada = '0;
    #12;
    chk("reset_val", 32'(salida), 32'h0);
    chk("reset_rco", 32'({RCO164, RCO163, RCO162, RCO}), 32'h0);
    @(negedge CLK);
    RESET_L = 1'b1;
    m_val = 0;

    // Asynchronous reset mid-count from 1234.
    step(1, 2'b11, 16'h1234, "ld1234");
    step(1, 2'b00, 16'h0000, "up1235");
    #2;
    RESET_L = 1'b0;
    #1;
    chk("async_rst_val", 32'(salida), 32'h0);
    chk("async_rst_rco", 32'({RCO164, RCO163, RCO162, RCO}), 32'h0);
    @(negedge CLK);
    RESET_L = 1'b1;
    m_val = 0;
    step(1, 2'b00, 16'h0000, "post_rst");

    // Load then count up across the byte boundary.
    step(1, 2'b11, 16'h00FE, "ld00FE");
    step(1, 2'b00, 16'h0000, "up00FF");
    step(1, 2'b00, 16'h0000, "up0100");
    step(1, 2'b00, 16'h0000, "up0101");

    // Full 16-bit wrap upward.
    step(1, 2'b11, 16'hFFFF, "ldFFFF");
    step(1, 2'b00, 16'h0000, "wrap_up");
    step(1, 2'b00, 16'h0000, "up0001");

    // Down by one across a nibble, then through zero.
    step(1, 2'b11, 16'h0010, "ld0010");
    step(1, 2'b01, 16'h0000, "dn000F");
    step(1, 2'b11, 16'h0000, "ld0000");
    step(1, 2'b01, 16'h0000, "wrap_dn");

    // Down by STEP_ALT.
    step(1, 2'b11, 16'h0005, "ld0005");
    step(1, 2'b10, 16'h0000, "dn3_0002");
    step(1, 2'b10, 16'h0000, "dn3_FFFF");
    step(1, 2'b10, 16'h0000, "dn3_FFFC");
    step(1, 2'b11, 16'h0001, "ld0001");
    step(1, 2'b10, 16'h0000, "dn3_FFFE");

    // Hold with MODO toggling, then load.
    step(1, 2'b11, 16'hABCD, "ldABCD");
    for (int i = 0; i < 4; i++) step(0, 2'(i), 16'h1111, "hold");
    step(1, 2'b11, 16'h5A5A, "ld5A5A");

    // Randomized traffic, with loads biased toward wrap-prone values.
    for (int i = 0; i < 600; i++) begin
      re = ($urandom_range(0, 7) != 0);
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: rv = 16'hFFFF;
        1: rv = 16'h0000;
        2: rv = 16'h0002;
        3: rv = {4'($urandom), 12'hFFF};
        4: rv = {12'h000, 4'($urandom)};
        default: rv = 16'($urandom);
      endcase
      step(re, rm, rv, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
